lieat_mul_seq_ctrl: RTL and testbench

//  Iterative RV32M multiplier sequencer. Owns one carry-save 3:2 compressor plus sum/carry

---
 rtl/lieat_mul_pkg.sv | 35 +++
 rtl/lieat_mul_seq_ctrl_compress.sv | 20 ++
 rtl/lieat_mul_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lieat_mul_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lieat_mul_pkg.sv
// Shared types and helpers for the iterative RV32M multiplier sequencer.
// Operand signedness per op is decided here so datapath and control agree.
package lieat_mul_pkg;

    localparam int MUL_WIDTH = 32;

    function automatic int acc_w_of(input int width);
        return 2 * width + 2;
    endfunction

    localparam int ACC_W = acc_w_of(MUL_WIDTH);

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CALC    = 2'b01,
        RESOLVE = 2'b10,
        DONE    = 2'b11
    } state_e;

    function automatic logic is_a_signed(input op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic is_b_signed(input op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/lieat_mul_seq_ctrl_compress.sv
// Generic 3:2 carry-save compressor; carry is already weighted (shifted left by one),
// so sum + carry == x + y + z modulo 2^WIDTH and carry bit 0 is always zero.
module lieat_general_compress32
    import lieat_mul_pkg::*;
#(
    parameter int WIDTH = ACC_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = {(x[WIDTH-2:0] & y[WIDTH-2:0]) |
                    (x[WIDTH-2:0] & z[WIDTH-2:0]) |
                    (y[WIDTH-2:0] & z[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/lieat_mul_seq_ctrl.sv
// Iterative RV32M multiplier: one carry-save partial-product fold per cycle, then one add.
// Optional early termination on exhausted multiplier bits: LIEAT_MUL_EARLY_TERM_EN.
module lieat_mul_seq_ctrl
    import lieat_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_o
);

    localparam int AW = acc_w_of(WIDTH);
    localparam int CW = $clog2(WIDTH + 1) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_e           state_r;
    state_e           state_nx_s;
    op_e              op_r;
    op_e              op_in_s;
    logic [WIDTH:0]   a_ext_r;
    logic [WIDTH:0]   b_sh_r;
    logic [AW-1:0]    acc_sum_r;
    logic [AW-1:0]    acc_carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [AW-1:0]      a_wide_s;
    logic [AW-1:0]      pp_s;
    logic [AW-1:0]      cmp_sum_s;
    logic [AW-1:0]      cmp_carry_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               accept_s;
    logic               last_step_s;
    logic               neg_step_s;
    logic               early_s;
    logic               fold_s;

    assign op_in_s  = op_e'(op_i);
    assign accept_s = (state_r == IDLE) && in_valid && !flush_i;

    // b is held as a right-shifting register, so bit 0 is always the multiplier bit at cnt.
    assign a_wide_s    = {{(AW-WIDTH-1){a_ext_r[WIDTH]}}, a_ext_r};
    assign last_step_s = (cnt_r == CNT_LAST);
    assign neg_step_s  = last_step_s && is_b_signed(op_r) && b_sh_r[0];

`ifdef LIEAT_MUL_EARLY_TERM_EN
    assign early_s = (state_r == CALC) && (b_sh_r == {(WIDTH+1){1'b0}});
`else
    assign early_s = 1'b0;
`endif

    assign fold_s = (state_r == CALC) && !early_s;

    // Partial product select; the signed top bit contributes -(a << WIDTH) as ~x + 1.
    always_comb begin
        pp_s = {AW{1'b0}};
        if (b_sh_r[0]) begin
            if (neg_step_s) begin
                pp_s = ~(a_wide_s << WIDTH);
            end else begin
                pp_s = a_wide_s << cnt_r;
            end
        end else begin
            pp_s = {AW{1'b0}};
        end
    end

    lieat_general_compress32 #(
        .WIDTH (AW)
    ) u_compress (
        .x     (acc_sum_r),
        .y     (acc_carry_r),
        .z     (pp_s),
        .sum   (cmp_sum_s),
        .carry (cmp_carry_s)
    );

    assign prod_s = acc_sum_r[2*WIDTH-1:0] + acc_carry_r[2*WIDTH-1:0];

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx_s = state_r;
        if (flush_i) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_nx_s = CALC;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                CALC: begin
                    if (early_s || last_step_s) begin
                        state_nx_s = RESOLVE;
                    end else begin
                        state_nx_s = CALC;
                    end
                end
                RESOLVE: begin
                    state_nx_s = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = DONE;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Operand capture and carry-save accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= MUL;
            a_ext_r     <= {(WIDTH+1){1'b0}};
            b_sh_r      <= {(WIDTH+1){1'b0}};
            acc_sum_r   <= {AW{1'b0}};
            acc_carry_r <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
        end else if (accept_s) begin
            op_r        <= op_in_s;
            a_ext_r     <= {is_a_signed(op_in_s) & a_i[WIDTH-1], a_i};
            b_sh_r      <= {is_b_signed(op_in_s) & b_i[WIDTH-1], b_i};
            acc_sum_r   <= {AW{1'b0}};
            acc_carry_r <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
        end else if (fold_s) begin
            acc_sum_r   <= cmp_sum_s;
            acc_carry_r <= cmp_carry_s | {{(AW-1){1'b0}}, neg_step_s};
            b_sh_r      <= b_sh_r >> 1;
            cnt_r       <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Final carry-propagate add; result is left untouched by a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
        end else if ((state_r == RESOLVE) && !flush_i) begin
            if (op_r == MUL) begin
                result_r <= prod_s[WIDTH-1:0];
            end else begin
                result_r <= prod_s[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result_o  = result_r;

endmodule

// File: tb/tb_lieat_mul_seq_ctrl.sv
// Self-checking bench for lieat_mul_seq_ctrl: directed corner ops plus randomized ops with
// stalls and flushes, compared against a plain-arithmetic product model.
module tb_lieat_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_o;

    int          n_chk;
    int          n_pass;
    logic [31:0] prev_result;

    lieat_mul_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Full-precision product of the operands as the op interprets them.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [65:0] ax;
        logic [65:0] bx;
        logic [65:0] p;
        ax = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
        bx = (op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Cycle (accept = 0) at which out_valid is first seen.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef LIEAT_MUL_EARLY_TERM_EN
        logic [32:0] bx;
        int          k;
        bx = {(op == 2'b01) & b[31], b};
        if (bx == 33'd0) return 3;
        k = 0;
        for (int i = 0; i < 33; i++) begin
            if (bx[i]) k = i;
        end
        return (k == 32) ? 35 : k + 4;
`else
        return 35;
`endif
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input int flush_at, input string tag);
        logic [31:0] exp_res;
        int          c;
        exp_res = ref_mul(op, a, b);
        @(negedge clk);
        chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op_i      = op;
        a_i       = a;
        b_i       = b;
        out_ready = 1'b0;
        @(negedge clk);
        c = 1;
        while (!out_valid && c < 200) begin
            if (c == flush_at) begin
                in_valid = 1'b0;
                flush_i  = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
                chk({tag, "_flush_ov"}, 32'(out_valid), 32'd0);
                chk({tag, "_flush_rdy"}, 32'(in_ready), 32'd1);
                chk({tag, "_flush_res"}, result_o, prev_result);
                return;
            end
            in_valid = 1'($urandom_range(0, 1));
            op_i     = 2'($urandom);
            a_i      = $urandom;
            b_i      = $urandom;
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(c), 32'(ref_lat(op, b)));
        chk({tag, "_res"}, result_o, exp_res);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold_res"}, result_o, exp_res);
            chk({tag, "_hold_busy"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
        prev_result = exp_res;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        prev_result = 32'd0;
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op_i        = 2'b00;
        a_i         = 32'd0;
        b_i         = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_res", result_o, 32'd0);
        rst_n = 1'b1;

        run_op(2'b00, 32'h0000_0007, 32'h0000_0006, 0, -1, "mul_7x6");
        chk("mul_7x6_val", prev_result, 32'h0000_002A);

        // Reset asserted in the middle of a calculation.
        @(negedge clk);
        in_valid = 1'b1;
        op_i     = 2'b00;
        a_i      = 32'd3;
        b_i      = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_rdy", 32'(in_ready), 32'd1);
        chk("midrst_res", result_o, 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        prev_result = 32'd0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, "mulh_m1");
        chk("mulh_m1_val", prev_result, 32'h0000_0000);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, "mulhu_m1");
        chk("mulhu_m1_val", prev_result, 32'hFFFF_FFFE);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, "mulhsu_min");
        chk("mulhsu_min_val", prev_result, 32'h8000_0000);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5, -1, "mulh_min_bp");
        chk("mulh_min_val", prev_result, 32'h4000_0000);

        run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 0, 20, "flush20");
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_0003, 0, -1, "after_flush");
        run_op(2'b00, 32'h0000_0005, 32'h0000_0000, 0, -1, "mul_5x0");

        // Flush in the same cycle as a valid request drops the request.
        @(negedge clk);
        in_valid = 1'b1;
        flush_i  = 1'b1;
        op_i     = 2'b00;
        a_i      = 32'd11;
        b_i      = 32'd13;
        @(negedge clk);
        in_valid = 1'b0;
        flush_i  = 1'b0;
        chk("drop_rdy", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("drop_ov", 32'(out_valid), 32'd0);
        chk("drop_res", result_o, prev_result);

        for (int n = 0; n < 1000; n++) begin
            int st;
            int fl;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 34)) : -1;
            run_op(2'($urandom), pick_operand(), pick_operand(), st, fl, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
